display_button_scanner: RTL and testbench

DISPLAY_BUTTON_SCANNER -- requirements
Module: display_button_scanner

---
 rtl/display_pkg.sv | 26 ++
 rtl/tick_gen.sv | 45 ++++
 rtl/display_button_scanner.sv | 195 +++++++++++++++++++
 tb/tb_display_button_scanner.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared definitions for the display-board button scanner:
//               scan FSM state encoding and default parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Default parameter values (50 MHz system clock)
    localparam int c_N_BITS    = 16;    // serial button bits per scan
    localparam int c_CLK_DIV   = 25;    // clk cycles per shift tick (2 MHz tick)
    localparam int c_GAP_TICKS = 2000;  // idle ticks between scans (1 ms)
    localparam int c_DEB_SCANS = 4;     // identical scans needed to accept

    // Scan FSM states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_HIGH   = 3'd3,
        ST_DONE   = 3'd4
    } scan_state_t;

endpackage : display_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running divider producing a one-cycle tick every
//               CLK_DIV clk cycles, counting from reset release.
// Ports       : clk   - system clock
//               reset - asynchronous active-high reset
//               tick  - registered one-cycle pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
    import display_pkg::*;
#(
    parameter int CLK_DIV = c_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int c_CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [c_CW-1:0] r_cnt;
    logic            r_tick;

    // The tick is registered one count early so it lands on the same cycle
    // a combinational (r_cnt == CLK_DIV-1) decode would, without the glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (r_cnt == c_CW'(CLK_DIV - 1)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
            r_tick <= (r_cnt == c_CW'(CLK_DIV - 2));
        end
    end

    assign tick = r_tick;

endmodule : tick_gen
`default_nettype wire

// File: rtl/display_button_scanner.sv
`default_nettype none
// ============================================================================
// Module      : display_button_scanner
// Description : Periodically reads the display-board 74HC165 button chain
//               (parallel load, then MSB-first serial shift), inverts the
//               active-low data and debounces it over DEB_SCANS scans.
// Ports       : clk, reset       - system clock, async active-high reset
//               enable           - keep scanning; low stops after current scan
//               shift_load       - register parallel load (active low)
//               shift_clkin      - register shift clock (rising edge shifts)
//               shift_out        - serial data from register (active low)
//               buttons          - debounced state, 1 = pressed
//               changed          - one-cycle pulse when buttons updates
//               scan_done        - one-cycle pulse at end of each scan
// Revision    : 1.0 - initial release
// ============================================================================
module display_button_scanner
    import display_pkg::*;
#(
    parameter int N_BITS    = c_N_BITS,
    parameter int CLK_DIV   = c_CLK_DIV,
    parameter int GAP_TICKS = c_GAP_TICKS,
    parameter int DEB_SCANS = c_DEB_SCANS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              shift_load,
    output logic              shift_clkin,
    input  logic              shift_out,
    output logic [N_BITS-1:0] buttons,
    output logic              changed,
    output logic              scan_done
);

    localparam int c_IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int c_GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int c_DW = $clog2(DEB_SCANS + 1);

    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(N_BITS - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_TICKS - 1);
    localparam logic [c_DW-1:0] c_DEB_MAX  = c_DW'(DEB_SCANS);

    logic              w_tick;
    logic              r_sync1;
    logic              r_sync2;
    scan_state_t       r_state;
    scan_state_t       w_state_nxt;
    logic [c_IW-1:0]   r_idx;
    logic [c_IW-1:0]   w_idx_nxt;
    logic [c_GW-1:0]   r_gap;
    logic [c_GW-1:0]   w_gap_nxt;
    logic [N_BITS-1:0] r_raw;
    logic [N_BITS-1:0] w_raw_nxt;
    logic              r_shift_load;
    logic              r_shift_clkin;
    logic              r_scan_done;
    logic [N_BITS-1:0] w_scan;
    logic [N_BITS-1:0] r_prev;
    logic [c_DW-1:0]   r_stable_cnt;
    logic [c_DW-1:0]   w_cnt_nxt;
    logic [N_BITS-1:0] r_buttons;
    logic              r_changed;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // Serial data arrives from another board; resynchronise before use
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= shift_out;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: state register and registered pin drives. The pins are
    // decoded from the next state so they change together with r_state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_gap         <= '0;
            r_raw         <= '0;
            r_shift_load  <= 1'b1;
            r_shift_clkin <= 1'b0;
            r_scan_done   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_gap         <= w_gap_nxt;
            r_raw         <= w_raw_nxt;
            r_shift_load  <= (w_state_nxt != ST_LOAD);
            r_shift_clkin <= (w_state_nxt == ST_HIGH);
            r_scan_done   <= (w_state_nxt == ST_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = r_gap;
        w_raw_nxt   = r_raw;
        case (r_state)
            ST_IDLE: begin
                // Once the gap has elapsed the counter holds, so a later
                // enable starts a scan on the very next tick.
                if (w_tick) begin
                    if (r_gap == c_GAP_LAST) begin
                        if (enable) begin
                            w_state_nxt = ST_LOAD;
                            w_gap_nxt   = '0;
                        end
                    end else begin
                        w_gap_nxt = r_gap + c_GW'(1);
                    end
                end
            end
            ST_LOAD: begin
                w_idx_nxt = '0;
                if (w_tick) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // Register presents MSB first
                if (w_tick) begin
                    w_raw_nxt[c_IDX_LAST - r_idx] = r_sync2;
                    w_state_nxt                   = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_tick) begin
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + c_IW'(1);
                        w_state_nxt = ST_SAMPLE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Debounce: stable_cnt is the saturating length of the current run of
    // identical scans; a new value is accepted only at full run length.
    // ------------------------------------------------------------------
    assign w_scan    = ~r_raw;
    assign w_cnt_nxt = (w_scan != r_prev)          ? c_DW'(1)     :
                       (r_stable_cnt == c_DEB_MAX) ? r_stable_cnt :
                                                     r_stable_cnt + c_DW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev       <= '0;
            r_stable_cnt <= '0;
            r_buttons    <= '0;
            r_changed    <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (r_state == ST_DONE) begin
                r_prev       <= w_scan;
                r_stable_cnt <= w_cnt_nxt;
                if ((w_cnt_nxt == c_DEB_MAX) && (w_scan != r_buttons)) begin
                    r_buttons <= w_scan;
                    r_changed <= 1'b1;
                end
            end
        end
    end

    assign shift_load  = r_shift_load;
    assign shift_clkin = r_shift_clkin;
    assign scan_done   = r_scan_done;
    assign buttons     = r_buttons;
    assign changed     = r_changed;

endmodule : display_button_scanner
`default_nettype wire

// File: tb/tb_display_button_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_button_scanner
// Description : Self-checking bench for display_button_scanner with a
//               74HC165 behavioural model and a scan-history debounce model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_button_scanner;

    localparam int N  = 16;
    localparam int CD = 4;
    localparam int GT = 8;
    localparam int DS = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         shift_out;
    logic         shift_load;
    logic         shift_clkin;
    logic [N-1:0] buttons;
    logic         changed;
    logic         scan_done;

    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

    display_button_scanner #(
        .N_BITS    (N),
        .CLK_DIV   (CD),
        .GAP_TICKS (GT),
        .DEB_SCANS (DS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .shift_load  (shift_load),
        .shift_clkin (shift_clkin),
        .shift_out   (shift_out),
        .buttons     (buttons),
        .changed     (changed),
        .scan_done   (scan_done)
    );

    // ---------------- 74HC165 model and activity monitor ----------------
    logic [N-1:0] par_in = '1;
    logic [N-1:0] sr = '1;
    logic [N-1:0] load_snap = '1;
    logic         prev_clkin = 1'b0;
    logic         prev_load = 1'b1;
    int rise_cnt = 0;
    int rise_while_load = 0;
    int changed_cnt = 0;
    int done_cnt = 0;
    int load_falls = 0;

    always @(negedge clk) begin
        if (!shift_load) begin
            sr        <= par_in;
            load_snap <= par_in;
        end else if (shift_clkin && !prev_clkin) begin
            sr <= {sr[N-2:0], 1'b1};
        end
        if (shift_clkin && !prev_clkin) begin
            rise_cnt = rise_cnt + 1;
            if (!shift_load) rise_while_load = rise_while_load + 1;
        end
        if (!shift_load && prev_load) load_falls = load_falls + 1;
        if (changed) changed_cnt = changed_cnt + 1;
        if (scan_done) done_cnt = done_cnt + 1;
        prev_clkin <= shift_clkin;
        prev_load  <= shift_load;
    end

    assign shift_out = sr[N-1];

    // ---------------- reference model: history of pressed sets ----------
    logic [N-1:0] hist [$];
    logic [N-1:0] m_buttons = '0;
    bit           m_chg = 1'b0;
    int           m_changes = 0;

    task automatic model_reset();
        hist.delete();
        m_buttons = '0;
        m_chg     = 1'b0;
    endtask

    // Accept a value once the last DS scans all read the same pressed set
    task automatic model_scan(input logic [N-1:0] pressed);
        bit same;
        hist.push_back(pressed);
        if (hist.size() > DS) void'(hist.pop_front());
        same = (hist.size() == DS);
        foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
        m_chg = same && (hist[0] != m_buttons);
        if (m_chg) begin
            m_buttons = hist[0];
            m_changes = m_changes + 1;
        end
    endtask

    task automatic abort_run(input string what);
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL %s: wait bound expired, required DUT event", what);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench stopped");
    endtask

    // Present val, run until scan_done, feed the model, sample one cycle later
    task automatic do_scan(input logic [N-1:0] val, output int rises,
                           output logic [N-1:0] btn, output logic chg);
        int r0;
        int n;
        par_in = val;
        r0 = rise_cnt;
        n = 0;
        while (scan_done !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 1000) abort_run("scan_timeout");
        end
        rises = rise_cnt - r0;
        model_scan(~load_snap);
        @(negedge clk);
        btn = buttons;
        chg = changed;
    endtask

    task automatic wait_rises(input int r0, input int target);
        int n;
        n = 0;
        while (!((rise_cnt - r0) == target && shift_clkin === 1'b1)) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 1000) abort_run("bit_wait_timeout");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int i;
        int j;
        int rises;
        logic [N-1:0] btn;
        logic chg;
        reset = 1'b1;
        enable = 1'b1;
        par_in = '1;
        repeat (3) @(negedge clk);
        checks++;
        if ({shift_load, shift_clkin, changed, scan_done} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_pins: load/clkin/changed/done=%b required 1000",
                     {shift_load, shift_clkin, changed, scan_done});
        end
        checks++;
        if (buttons !== 16'h0000) begin
            failures++;
            $display("FAIL reset_buttons: got %h required 0000", buttons);
        end
        reset = 1'b0;
        model_reset();
        i = 0;
        while (shift_load === 1'b1 && i < 200) begin @(negedge clk); i++; end
        checks++;
        if (i != 32) begin
            failures++;
            $display("FAIL first_load_delay: got %0d cycles required 32", i);
        end
        j = 0;
        while (shift_load === 1'b0 && j < 50) begin @(negedge clk); j++; end
        checks++;
        if (j != 4) begin
            failures++;
            $display("FAIL load_width: got %0d cycles required 4", j);
        end
        do_scan('1, rises, btn, chg);
        checks++;
        if (rises != 16 || btn !== 16'h0000 || chg !== 1'b0) begin
            failures++;
            $display("FAIL first_scan: rises=%0d btn=%h chg=%b required 16 0000 0",
                     rises, btn, chg);
        end
    endtask

    task automatic test_press();
        int rises;
        int c0;
        logic [N-1:0] btn;
        logic chg;
        c0 = changed_cnt;
        do_scan(16'hFFFE, rises, btn, chg);
        checks++;
        if (rises != 16 || btn !== 16'h0000 || chg !== 1'b0) begin
            failures++;
            $display("FAIL press_scan1: rises=%0d btn=%h chg=%b required 16 0000 0",
                     rises, btn, chg);
        end
        do_scan(16'hFFFE, rises, btn, chg);
        checks++;
        if (rises != 16 || btn !== 16'h0001 || chg !== 1'b1) begin
            failures++;
            $display("FAIL press_scan2: rises=%0d btn=%h chg=%b required 16 0001 1",
                     rises, btn, chg);
        end
        @(negedge clk);
        #1;
        checks++;
        if (changed_cnt - c0 != 1) begin
            failures++;
            $display("FAIL press_pulses: got %0d changed cycles required 1", changed_cnt - c0);
        end
    endtask

    task automatic test_glitch();
        logic [N-1:0] seq [3] = '{16'h7FFE, 16'hFFFE, 16'hFFFE};
        int rises;
        int c0;
        logic [N-1:0] btn;
        logic chg;
        c0 = changed_cnt;
        foreach (seq[k]) begin
            do_scan(seq[k], rises, btn, chg);
            checks++;
            if (btn !== 16'h0001 || chg !== 1'b0) begin
                failures++;
                $display("FAIL glitch_scan%0d: btn=%h chg=%b required 0001 0", k, btn, chg);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (changed_cnt != c0) begin
            failures++;
            $display("FAIL glitch_pulses: got %0d changed cycles required 0", changed_cnt - c0);
        end
    endtask

    task automatic test_release();
        int rises;
        int c0;
        logic [N-1:0] btn;
        logic chg;
        c0 = changed_cnt;
        do_scan(16'hFFFF, rises, btn, chg);
        checks++;
        if (btn !== 16'h0001 || chg !== 1'b0) begin
            failures++;
            $display("FAIL release_scan1: btn=%h chg=%b required 0001 0", btn, chg);
        end
        do_scan(16'hFFFF, rises, btn, chg);
        checks++;
        if (btn !== 16'h0000 || chg !== 1'b1) begin
            failures++;
            $display("FAIL release_scan2: btn=%h chg=%b required 0000 1", btn, chg);
        end
        @(negedge clk);
        #1;
        checks++;
        if (changed_cnt - c0 != 1) begin
            failures++;
            $display("FAIL release_pulses: got %0d changed cycles required 1", changed_cnt - c0);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        int rises;
        int c0;
        int mc0;
        logic [N-1:0] btn;
        logic chg;
        v = 16'hA5A5;
        c0 = changed_cnt;
        mc0 = m_changes;
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 2) == 0) v = N'($urandom);
            do_scan(v, rises, btn, chg);
            checks++;
            if (rises != 16) begin
                failures++;
                $display("FAIL rand_rises[%0d]: got %0d required 16", k, rises);
            end
            checks++;
            if (btn !== m_buttons || chg !== m_chg) begin
                failures++;
                $display("FAIL rand_out[%0d]: btn=%h chg=%b required %h %b",
                         k, btn, chg, m_buttons, m_chg);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (changed_cnt - c0 != m_changes - mc0) begin
            failures++;
            $display("FAIL rand_pulses: got %0d required %0d", changed_cnt - c0, m_changes - mc0);
        end
        checks++;
        if (rise_while_load != 0) begin
            failures++;
            $display("FAIL clk_during_load: got %0d edges required 0", rise_while_load);
        end
    endtask

    task automatic test_reset_mid_scan();
        int rises;
        int r0;
        int d0;
        int i;
        logic [N-1:0] btn;
        logic chg;
        // Get a nonzero debounced value so reset has something to clear
        do_scan(16'h5AFF, rises, btn, chg);
        do_scan(16'h5AFF, rises, btn, chg);
        checks++;
        if (btn !== 16'hA500) begin
            failures++;
            $display("FAIL pre_reset_btn: got %h required a500", btn);
        end
        par_in = 16'h00FF;
        r0 = rise_cnt;
        wait_rises(r0, 8);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        checks++;
        if ({shift_load, shift_clkin, changed, scan_done} !== 4'b1000 || buttons !== '0) begin
            failures++;
            $display("FAIL async_reset: pins=%b btn=%h required 1000 0000",
                     {shift_load, shift_clkin, changed, scan_done}, buttons);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        i = 0;
        while (shift_load === 1'b1 && i < 200) begin @(negedge clk); i++; end
        checks++;
        if (i != 32) begin
            failures++;
            $display("FAIL reload_delay: got %0d cycles required 32", i);
        end
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL aborted_done: got %0d scan_done cycles required 0", done_cnt - d0);
        end
        do_scan(16'h00FF, rises, btn, chg);
        checks++;
        if (rises != 16 || btn !== 16'h0000 || chg !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_scan: rises=%0d btn=%h chg=%b required 16 0000 0",
                     rises, btn, chg);
        end
    endtask

    task automatic test_enable_drop();
        int rises;
        int r0;
        int f0;
        int d0;
        logic [N-1:0] btn;
        logic chg;
        par_in = 16'h00FF;
        r0 = rise_cnt;
        wait_rises(r0, 4);
        enable = 1'b0;
        do_scan(16'h00FF, rises, btn, chg);
        checks++;
        if (rises != 12 || btn !== 16'hFF00 || chg !== 1'b1) begin
            failures++;
            $display("FAIL drop_scan: rises=%0d btn=%h chg=%b required 12 ff00 1",
                     rises, btn, chg);
        end
        f0 = load_falls;
        d0 = done_cnt;
        repeat (300) @(negedge clk);
        checks++;
        if (load_falls != f0 || done_cnt != d0) begin
            failures++;
            $display("FAIL disabled_idle: loads=%0d dones=%0d required 0 0",
                     load_falls - f0, done_cnt - d0);
        end
        enable = 1'b1;
        do_scan(16'hFFFF, rises, btn, chg);
        checks++;
        if (rises != 16 || btn !== m_buttons || chg !== m_chg) begin
            failures++;
            $display("FAIL resume_scan: rises=%0d btn=%h chg=%b required 16 %h %b",
                     rises, btn, chg, m_buttons, m_chg);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_release();
        test_random();
        test_reset_mid_scan();
        test_enable_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_display_button_scanner
`default_nettype wire
